// File: rtl/ct_fadd_close_h_sched_if.sv
// Bundle for the close-path scheduler: lane requests, the shared datapath hookup and the result port.
// The scheduler uses the slave modport; the surrounding issue/datapath/consumer logic uses master.
interface ct_fadd_close_h_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
);
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*12-1:0]    req_src0;
  logic [NUM_REQ*12-1:0]    req_src1;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_gnt;
  logic                     flush;

  logic [11:0]              dp_adder0;
  logic [11:0]              dp_adder1;
  logic [11:0]              dp_close_sum;
  logic [11:0]              dp_close_sum_m1;
  logic                     dp_close_op_chg;
  logic [5:0]               dp_ff1_pred;

  logic                     rslt_vld;
  logic                     rslt_rdy;
  logic [11:0]              rslt_sum;
  logic [11:0]              rslt_sum_m1;
  logic                     rslt_op_chg;
  logic [5:0]               rslt_ff1_pred;
  logic [TAG_W-1:0]         rslt_tag;
  logic [2:0]               rslt_id;
  logic                     busy;

  modport master (
    output req_vld, req_src0, req_src1, req_tag, flush,
    output dp_close_sum, dp_close_sum_m1, dp_close_op_chg, dp_ff1_pred,
    output rslt_rdy,
    input  req_gnt, dp_adder0, dp_adder1,
    input  rslt_vld, rslt_sum, rslt_sum_m1, rslt_op_chg, rslt_ff1_pred,
    input  rslt_tag, rslt_id, busy
  );

  modport slave (
    input  req_vld, req_src0, req_src1, req_tag, flush,
    input  dp_close_sum, dp_close_sum_m1, dp_close_op_chg, dp_ff1_pred,
    input  rslt_rdy,
    output req_gnt, dp_adder0, dp_adder1,
    output rslt_vld, rslt_sum, rslt_sum_m1, rslt_op_chg, rslt_ff1_pred,
    output rslt_tag, rslt_id, busy
  );
endinterface

// File: rtl/ct_fadd_close_h_sched.sv
// Round-robin scheduler sharing one half-precision close-path subtract/LZA datapath between lanes.
// S1 holds the operands driven to the datapath; S2 captures the datapath result with its tag and owner.
module ct_fadd_close_h_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  ct_fadd_close_h_sched_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [3:0] NUM_REQ4 = 4'(NUM_REQ);

  logic                     r_s1_vld;
  logic                     r_s2_vld;
  logic [2:0]               r_ptr;
  logic [11:0]              r_adder0;
  logic [11:0]              r_adder1;
  logic [TAG_W-1:0]         r_s1_tag;
  logic [2:0]               r_s1_id;
  logic [11:0]              r_sum;
  logic [11:0]              r_sum_m1;
  logic                     r_op_chg;
  logic [5:0]               r_ff1_pred;
  logic [TAG_W-1:0]         r_s2_tag;
  logic [2:0]               r_s2_id;

  logic                     w_s2_free;
  logic                     w_s1_adv;
  logic                     w_s1_free;
  logic                     w_arb_en;
  logic [2*NUM_REQ-1:0]     w_req_rot;
  logic                     w_gnt_any;
  logic [2:0]               w_gnt_off;
  logic [3:0]               w_gnt_sum;
  logic [2:0]               w_gnt_idx;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [2:0]               w_ptr_nxt;
  logic [11:0]              w_sel_src0;
  logic [11:0]              w_sel_src1;
  logic [TAG_W-1:0]         w_sel_tag;

  assign w_s2_free = !r_s2_vld || bus.rslt_rdy;
  assign w_s1_adv  = r_s1_vld && w_s2_free;
  assign w_s1_free = !r_s1_vld || w_s1_adv;
  // Reset is folded in so no grant can leak out while the pipeline is being cleared.
  assign w_arb_en  = w_s1_free && !bus.flush && !cpurst;

  // Rotate the request vector so the search always starts at the pointer, then
  // find the first set bit and map its offset back to an absolute lane index.
  always_comb begin
    w_req_rot = {bus.req_vld, bus.req_vld} >> r_ptr;
    w_gnt_any = 1'b0;
    w_gnt_off = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_any && w_arb_en && w_req_rot[k]) begin
        w_gnt_any = 1'b1;
        w_gnt_off = 3'(k);
      end
    end
    w_gnt_sum = {1'b0, r_ptr} + {1'b0, w_gnt_off};
    if (w_gnt_sum >= NUM_REQ4) begin
      w_gnt_sum = w_gnt_sum - NUM_REQ4;
    end
    w_gnt_idx = w_gnt_sum[2:0];
    w_ptr_nxt = (w_gnt_idx == LAST_IDX) ? 3'd0 : w_gnt_idx + 3'd1;
  end

  always_comb begin
    w_gnt      = '0;
    w_sel_src0 = '0;
    w_sel_src1 = '0;
    w_sel_tag  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_idx == 3'(k)) begin
        w_gnt[k]   = w_gnt_any;
        w_sel_src0 = bus.req_src0[k*12 +: 12];
        w_sel_src1 = bus.req_src1[k*12 +: 12];
        w_sel_tag  = bus.req_tag[k*TAG_W +: TAG_W];
      end
    end
  end

  // Flush only drops the valids; pointer and operand registers keep their contents.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_s1_vld <= 1'b0;
      r_ptr    <= 3'd0;
      r_adder0 <= '0;
      r_adder1 <= '0;
      r_s1_tag <= '0;
      r_s1_id  <= '0;
    end else if (bus.flush) begin
      r_s1_vld <= 1'b0;
    end else if (w_gnt_any) begin
      r_s1_vld <= 1'b1;
      r_ptr    <= w_ptr_nxt;
      r_adder0 <= w_sel_src0;
      r_adder1 <= w_sel_src1;
      r_s1_tag <= w_sel_tag;
      r_s1_id  <= w_gnt_idx;
    end else if (w_s1_free) begin
      r_s1_vld <= 1'b0;
    end
  end

  // A capture while the old result is being accepted replaces it, keeping rslt_vld high.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_s2_vld   <= 1'b0;
      r_sum      <= '0;
      r_sum_m1   <= '0;
      r_op_chg   <= 1'b0;
      r_ff1_pred <= '0;
      r_s2_tag   <= '0;
      r_s2_id    <= '0;
    end else if (bus.flush) begin
      r_s2_vld <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_vld   <= 1'b1;
      r_sum      <= bus.dp_close_sum;
      r_sum_m1   <= bus.dp_close_sum_m1;
      r_op_chg   <= bus.dp_close_op_chg;
      r_ff1_pred <= bus.dp_ff1_pred;
      r_s2_tag   <= r_s1_tag;
      r_s2_id    <= r_s1_id;
    end else if (r_s2_vld && bus.rslt_rdy) begin
      r_s2_vld <= 1'b0;
    end
  end

  assign bus.req_gnt       = w_gnt;
  assign bus.dp_adder0     = r_adder0;
  assign bus.dp_adder1     = r_adder1;
  assign bus.rslt_vld      = r_s2_vld;
  assign bus.rslt_sum      = r_sum;
  assign bus.rslt_sum_m1   = r_sum_m1;
  assign bus.rslt_op_chg   = r_op_chg;
  assign bus.rslt_ff1_pred = r_ff1_pred;
  assign bus.rslt_tag      = r_s2_tag;
  assign bus.rslt_id       = r_s2_id;
  assign bus.busy          = r_s1_vld || r_s2_vld;

endmodule
